grid_write_sched: RTL

- Schedules all writes into the VGA colour-grid memory inside mcu_io.
- Sources: (a) MCU output port pair, grid position (MSB byte) and colour (LSB byte); (b) an internal clear/fill sweep.
- Converts level-style MCU outputs into discrete write requests and buffers them in a small FIFO.
- Arbitrates the FIFO against the clear sweep and drives one valid/ready write port toward the grid memory.

---
 rtl/grid_sched_pkg.sv | 20 ++
 rtl/grid_wr_fifo.sv | 54 +++++
 rtl/grid_write_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/grid_sched_pkg.sv
// Shared types for the grid write scheduler: FSM encoding, field widths and
// the FIFO entry layout.
package grid_sched_pkg;

    localparam int GRID_ADDR_W = 8;
    localparam int COLOR_W     = 8;
    localparam int ENTRY_W     = GRID_ADDR_W + COLOR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [GRID_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]     color;
    } grid_wr_entry_t;

endpackage

// File: rtl/grid_wr_fifo.sv
// Small synchronous FIFO with a register-backed head; push and pop may
// coincide at any occupancy, including full.
module grid_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_write_sched.sv
// Merges MCU grid writes (edge-detected and buffered) with a full-grid clear
// sweep onto one valid/ready write port toward the colour-grid memory.
module grid_write_sched
    import grid_sched_pkg::*;
#(
    parameter int         GRID_CELLS = 64,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CLR_COLOR  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mcu_pos,
    input  logic [7:0] mcu_color,
    input  logic       clr_req,
    output logic       gw_valid,
    output logic [7:0] gw_addr,
    output logic [7:0] gw_data,
    input  logic       gw_ready,
    output logic       busy,
    output logic       ovf,
    input  logic       ovf_clr
);
    localparam logic [GRID_ADDR_W-1:0] LAST_CELL = GRID_ADDR_W'(GRID_CELLS - 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t           state_reg;
    logic [GRID_ADDR_W-1:0] cnt_reg;
    logic                   clr_pend_reg;
    logic                   arm_reg;
    logic [ENTRY_W-1:0]     last_reg;
    logic                   ovf_reg;

    grid_wr_entry_t         cur_entry;
    grid_wr_entry_t         head_entry;
    logic [ENTRY_W-1:0]     head_bits;
    logic                   push;
    logic                   push_ok;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LW-1:0]          fifo_level;

    assign cur_entry  = '{addr: mcu_pos, color: mcu_color};
    assign push       = arm_reg && (cur_entry != last_reg);
    assign pop        = (state_reg == S_DRAIN) && gw_ready && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign head_entry = grid_wr_entry_t'(head_bits);

    grid_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cur_entry),
        .pop   (pop),
        .head  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            clr_pend_reg <= 1'b0;
            arm_reg      <= 1'b0;
            last_reg     <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            // First live cycle only captures the MCU value so a stale port
            // level is not replayed as a write.
            if (!arm_reg) begin
                arm_reg  <= 1'b1;
                last_reg <= cur_entry;
            end else if (cur_entry != last_reg) begin
                last_reg <= cur_entry;
            end

            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end

            if (clr_req && state_reg != S_CLEAR) begin
                clr_pend_reg <= 1'b1;
            end

            // Transitions into CLEAR consume the pending request last, so a
            // request landing on that same edge merges into this sweep.
            case (state_reg)
                S_IDLE: begin
                    if (clr_pend_reg) begin
                        state_reg    <= S_CLEAR;
                        cnt_reg      <= '0;
                        clr_pend_reg <= 1'b0;
                    end else if (!fifo_empty || push_ok) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (gw_ready) begin
                        if (clr_pend_reg) begin
                            state_reg    <= S_CLEAR;
                            cnt_reg      <= '0;
                            clr_pend_reg <= 1'b0;
                        end else if (fifo_level > LW'(1) || push_ok) begin
                            state_reg <= S_DRAIN;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_CLEAR: begin
                    if (gw_ready) begin
                        if (cnt_reg == LAST_CELL) begin
                            state_reg <= (!fifo_empty || push_ok) ? S_DRAIN : S_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        gw_addr = '0;
        gw_data = '0;
        case (state_reg)
            S_DRAIN: begin
                gw_addr = head_entry.addr;
                gw_data = head_entry.color;
            end
            S_CLEAR: begin
                gw_addr = cnt_reg;
                gw_data = CLR_COLOR;
            end
            default: ;
        endcase
    end

    assign gw_valid = (state_reg != S_IDLE);
    assign busy     = clr_pend_reg || (state_reg == S_CLEAR);
    assign ovf      = ovf_reg;

endmodule
